// File: rtl/pwm_generator_mc.sv
// Multi-channel PWM generator: shared period counter, double-buffered compares,
// and a 4-state command pipeline that turns signed Q1.(DATA_W-1) duty into compare counts.
module pwm_generator_mc #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned PWM_FREQ = 20_000,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned DATA_W   = 16,
  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              aclk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              center_mode,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [DATA_W-1:0] cmd_duty,
  output logic              cmd_err,
  output logic [N_CH-1:0]   pwm_out,
  output logic [N_CH-1:0]   dir_out,
  output logic              period_start
);

  localparam int unsigned PERIOD = CLK_HZ / PWM_FREQ;
  localparam int unsigned CNT_W  = $clog2(PERIOD + 1);
  localparam int unsigned PROD_W = DATA_W + CNT_W;

  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  PERIOD_C = CNT_W'(PERIOD);
  localparam logic [DATA_W-1:0] NEG_FULL = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] POS_FULL = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, ABS, MUL, WRITE} cmd_state_e;

  cmd_state_e state_q, state_d;

  logic              alive_q;
  logic [CH_W-1:0]   ch_q;
  logic [DATA_W-1:0] duty_q;
  logic [DATA_W-1:0] mag_q, mag_d;
  logic              sign_q;
  logic [CNT_W-1:0]  cmp_q, cmp_d;
  logic [PROD_W-1:0] prod, prod_sh;
  logic              accept, wr_en, ch_ok;

  logic [CNT_W-1:0]  cnt_q;
  logic              xfer;

  logic [CNT_W-1:0]  shadow_cmp [N_CH];
  logic [N_CH-1:0]   shadow_dir;
  logic [CNT_W-1:0]  active_cmp [N_CH];
  logic [CNT_W-1:0]  start_q    [N_CH];
  logic [N_CH-1:0]   active_dir;
  logic              mode_active;
  logic [CNT_W-1:0]  xfer_cmp   [N_CH];
  logic [N_CH-1:0]   xfer_dir;
  logic [N_CH-1:0]   pwm_d, pwm_q;

  // Holds cmd_ready low while reset is asserted and for the first edge after.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) alive_q <= 1'b0;
    else        alive_q <= 1'b1;
  end

  assign ch_ok = (32'(ch_q) < N_CH);

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    wr_en     = 1'b0;
    cmd_err   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = alive_q;
        if (cmd_valid && alive_q) begin
          accept  = 1'b1;
          state_d = ABS;
        end
      end
      ABS:   state_d = MUL;
      MUL:   state_d = WRITE;
      WRITE: begin
        wr_en   = ch_ok;
        cmd_err = !ch_ok;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The most negative code has no positive twin; saturate it to full scale.
  always_comb begin
    if (duty_q == NEG_FULL)      mag_d = POS_FULL;
    else if (duty_q[DATA_W-1])   mag_d = ~duty_q + DATA_W'(1);
    else                         mag_d = duty_q;
  end

  always_comb begin
    prod    = PROD_W'(mag_q) * PROD_W'(PERIOD);
    prod_sh = prod >> (DATA_W - 1);
    cmp_d   = (prod_sh > PROD_W'(PERIOD)) ? PERIOD_C : prod_sh[CNT_W-1:0];
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q   <= '0;
      duty_q <= '0;
      mag_q  <= '0;
      sign_q <= 1'b0;
      cmp_q  <= '0;
    end else begin
      if (accept) begin
        ch_q   <= cmd_ch;
        duty_q <= cmd_duty;
      end
      if (state_q == ABS) begin
        sign_q <= duty_q[DATA_W-1];
        mag_q  <= mag_d;
      end
      if (state_q == MUL) cmp_q <= cmp_d;
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n)                 cnt_q <= '0;
    else if (!enable)           cnt_q <= '0;
    else if (cnt_q == LAST_CNT) cnt_q <= '0;
    else                        cnt_q <= cnt_q + CNT_W'(1);
  end

  assign xfer         = !enable || (cnt_q == LAST_CNT);
  assign period_start = alive_q && enable && (cnt_q == '0);

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CH; i++) shadow_cmp[i] <= '0;
      shadow_dir <= '1;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (wr_en && (ch_q == CH_W'(i))) begin
          shadow_cmp[i] <= cmp_q;
          shadow_dir[i] <= ~sign_q;
        end
      end
    end
  end

  // A write landing on the transfer cycle is forwarded straight into the active set.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      xfer_cmp[i] = (wr_en && (ch_q == CH_W'(i))) ? cmp_q   : shadow_cmp[i];
      xfer_dir[i] = (wr_en && (ch_q == CH_W'(i))) ? ~sign_q : shadow_dir[i];
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        active_cmp[i] <= '0;
        start_q[i]    <= '0;
      end
      active_dir  <= '1;
      mode_active <= 1'b0;
    end else if (xfer) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        active_cmp[i] <= xfer_cmp[i];
        start_q[i]    <= (PERIOD_C - xfer_cmp[i]) >> 1;
      end
      active_dir  <= xfer_dir;
      mode_active <= center_mode;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (mode_active)
        pwm_d[i] = (cnt_q >= start_q[i]) && (cnt_q < start_q[i] + active_cmp[i]);
      else
        pwm_d[i] = (cnt_q < active_cmp[i]);
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) pwm_q <= '0;
    else        pwm_q <= enable ? pwm_d : '0;
  end

  assign pwm_out = pwm_q;
  assign dir_out = active_dir;

endmodule
